// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state (trailing checksum byte).
package imem_loader_pkg;
  localparam int ARQ              = 16;
  localparam int MEMORY_ADDR_SIZE = 6;
  localparam int IMEM_DEPTH       = 64;
  localparam int BYTE_W           = 8;

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    LOW,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                        start;
  logic [MEMORY_ADDR_SIZE:0]   num_words;
  logic                        byte_valid;
  logic [BYTE_W-1:0]           byte_data;
  logic                        byte_ready;
  logic                        wr_en;
  logic [MEMORY_ADDR_SIZE-1:0] wr_addr;
  logic [ARQ-1:0]              wr_data;
  logic                        core_hold;
  logic                        done;
  logic                        error;

  modport master (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, core_hold, done, error
  );

  modport slave (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, core_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: byte stream -> 16-bit words written at addresses 0..N-1.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
(
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  state_t                      state;
  logic [MEMORY_ADDR_SIZE:0]   count;
  logic [MEMORY_ADDR_SIZE-1:0] wr_addr;
  logic [ARQ-1:0]              wr_data;
  logic [MEMORY_ADDR_SIZE:0]   clamped;
  logic                        last;

  assign clamped = (bus.num_words > (MEMORY_ADDR_SIZE+1)'(IMEM_DEPTH))
                   ? (MEMORY_ADDR_SIZE+1)'(IMEM_DEPTH) : bus.num_words;
  assign last    = ({1'b0, wr_addr} + 1'b1) == count;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  logic              err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum    <= '0;
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            count   <= clamped;
            wr_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= '0;
            err     <= 1'b0;
`endif
            state   <= (clamped == '0) ? DONE : HIGH;
          end
        end
        HIGH: begin
          if (bus.byte_valid) begin
            wr_data[ARQ-1:BYTE_W] <= bus.byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.byte_data;
`endif
            state <= LOW;
          end
        end
        LOW: begin
          if (bus.byte_valid) begin
            wr_data[BYTE_W-1:0] <= bus.byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.byte_data;
`endif
            state <= WRITE;
          end
        end
        WRITE: begin
          // Address holds on the last word so a full 64-word load never wraps.
          if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state <= DONE;
`endif
          end else begin
            wr_addr <= wr_addr + 1'b1;
            state   <= HIGH;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (bus.byte_valid) begin
            if (bus.byte_data != csum) err <= 1'b1;
            state <= DONE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = wr_data;
  assign bus.wr_en      = (state == WRITE);
  assign bus.done       = (state == DONE);
  assign bus.core_hold  = (state != IDLE) && (state != DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.byte_ready = (state == HIGH) || (state == LOW) || (state == CHECK);
  assign bus.error      = err;
`else
  assign bus.byte_ready = (state == HIGH) || (state == LOW);
  assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads with random payloads
// checked against a word-list model, plus reset/zero/checksum sequences.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if bus ();
  imem_loader dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]  log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];
  int          done_cyc;
  logic        done_q = 1'b0;
  logic [7:0]  preset[$];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back(bus.wr_data);
      log_cyc.push_back(cyc);
    end
    if (bus.done && !done_q) done_cyc = cyc;
    done_q = bus.done;
  end

  typedef struct {
    int n;
    int gap;
    bit bad_csum;
    bit poke;
    int exp_writes;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready) chk("send_timeout", 32'd0, 32'd1);
    else @(negedge clk);
  endtask

  task automatic idle_gap(input int g);
    bus.byte_valid = 1'b0;
    repeat (g) begin
      @(negedge clk);
      chk("gap_ready", bus.byte_ready, 1);
      chk("gap_wr_en", bus.wr_en, 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, bus.byte_ready, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_hold"},  bus.core_hold, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_addr"},  bus.wr_addr, 0);
    chk({tag, "_data"},  bus.wr_data, 0);
  endtask

  // Model: word i = {byte[2i], byte[2i+1]} at address i, min(n,64) words.
  task automatic run_load(input int n, input int gap, input bit bad_csum,
                          input bit poke, input int exp_writes);
    logic [7:0] q[$];
    logic [7:0] x, hi, lo;
    int eff, k;
    bit exp_err;
    eff = (n > IMEM_DEPTH) ? IMEM_DEPTH : n;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    done_cyc = -1;
    x = 8'h00;
    bus.start = 1'b1;
    bus.num_words = 7'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold_after_start", bus.core_hold, (eff != 0));
    if (eff == 0) chk("zero_done_next", bus.done, 1);
    for (int w = 0; w < eff; w++) begin
      if (preset.size() >= 2) begin
        hi = preset.pop_front();
        lo = preset.pop_front();
      end else begin
        hi = 8'($urandom);
        lo = 8'($urandom);
      end
      q.push_back(hi);
      q.push_back(lo);
      if (poke && w == 1) begin
        bus.start = 1'b1;
        bus.num_words = 7'd3;
      end
      send(hi);
      bus.start = 1'b0;
      if (gap > 0) idle_gap(gap);
      send(lo);
      x = x ^ hi ^ lo;
    end
    exp_err = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (eff > 0) begin
      if (bad_csum) send((x == 8'h00) ? 8'hFF : 8'h00);
      else send(x);
      exp_err = bad_csum;
    end
`endif
    bus.byte_valid = 1'b0;
    k = 0;
    while (!bus.done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("done_set", bus.done, 1);
    @(negedge clk);
    chk("write_count", log_addr.size(), exp_writes);
    chk("write_count_model", log_addr.size(), eff);
    for (int i = 0; i < log_addr.size() && i < eff; i++) begin
      chk($sformatf("addr[%0d]", i), log_addr[i], i);
      chk($sformatf("data[%0d]", i), log_data[i], {q[2*i], q[2*i+1]});
      if (gap == 0 && i > 0)
        chk($sformatf("spacing[%0d]", i), log_cyc[i] - log_cyc[i-1], 3);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (eff > 0 && log_cyc.size() > 0)
      chk("done_latency", done_cyc, log_cyc[log_cyc.size()-1] + 1);
`endif
    chk("hold_end", bus.core_hold, 0);
    chk("error_end", bus.error, exp_err);
  endtask

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n: 2,   gap: 0,  bad_csum: 0, poke: 0, exp_writes: 2};
    tbl[1] = '{n: 3,   gap: 10, bad_csum: 0, poke: 0, exp_writes: 3};
    tbl[2] = '{n: 100, gap: 0,  bad_csum: 0, poke: 0, exp_writes: 64};
    tbl[3] = '{n: 5,   gap: 0,  bad_csum: 0, poke: 1, exp_writes: 5};
    tbl[4] = '{n: 1,   gap: 2,  bad_csum: 1, poke: 0, exp_writes: 1};
    tbl[5] = '{n: 64,  gap: 1,  bad_csum: 0, poke: 0, exp_writes: 64};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_words = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero-word load straight from IDLE.
    run_load(0, 0, 0, 0, 0);

    // Basic load with fixed bytes.
    preset = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_load(2, 0, 0, 0, 2);
    if (log_data.size() == 2) begin
      chk("basic_w0", log_data[0], 16'h1234);
      chk("basic_w1", log_data[1], 16'hABCD);
    end

    foreach (tbl[i]) run_load(tbl[i].n, tbl[i].gap, tbl[i].bad_csum, tbl[i].poke, tbl[i].exp_writes);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 70));
      run_load(n, int'($urandom_range(0, 3)), 1'($urandom), 0, (n > 64) ? 64 : n);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    preset = '{8'h12, 8'h34};
    run_load(1, 0, 0, 0, 1);
    chk("csum_good_err", bus.error, 0);
    preset = '{8'h12, 8'h34};
    run_load(1, 0, 1, 0, 1);
    chk("csum_bad_err", bus.error, 1);
`endif

    // Reset after the third of five words is being written.
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    bus.start = 1'b1;
    bus.num_words = 7'd5;
    @(negedge clk);
    bus.start = 1'b0;
    for (int b = 0; b < 6; b++) send(8'($urandom));
    bus.byte_valid = 1'b0;
    chk("midload_wr_en", bus.wr_en, 1);
    chk("midload_addr", bus.wr_addr, 2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    chk("midreset_writes", log_addr.size(), 3);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle_hold", bus.core_hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake, assembles bytes into ARQ-bit instruction words (high byte first) and issues one write per word at sequential addresses starting at 0. While a load is in progress it asserts a hold signal so that the fetch stage's PC stays stopped.

## Interface
- ARQ, 16: instruction word width in bits; fixed at 16, two bytes per word.
- MEMORY_ADDR_SIZE, 6: instruction memory address width; depth is 2**MEMORY_ADDR_SIZE = 64 words.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- num_words  in  MEMORY_ADDR_SIZE+1  word count, sampled when start is accepted; 0 means an empty load; values above 64 are clamped to 64.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer is valid & ready.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  MEMORY_ADDR_SIZE  write address.
- wr_data  out  ARQ  assembled word, {high byte, low byte}.
- core_hold  out  1  high while the loader is busy; drives the fetch stage's PC enable low.
- done  out  1  sticky load-complete flag.
- error  out  1  sticky checksum-mismatch flag.

## Operation
- States: IDLE, HIGH, LOW, WRITE, CHECK, DONE.
- IDLE/DONE, start=1:
  - Latch the clamped count and clear the address counter, done and error.
  - Go to HIGH, or to DONE if the count is 0.
- HIGH: byte_ready=1. On a transfer, store byte_data in wr_data[15:8] and go to LOW.
- LOW: byte_ready=1. On a transfer, store byte_data in wr_data[7:0] and go to WRITE.
- WRITE: wr_en=1 with the current wr_addr.
  - Next cycle, wr_addr increments by 1.
  - If this was the last word, go to CHECK (macro defined) or DONE; otherwise go to HIGH.
- CHECK: see Configuration.
- DONE: done=1 and core_hold=0. Stay until the next start.
- The address never wraps: at most 64 words, and the last write uses address 63.
- start in HIGH, LOW, WRITE or CHECK is ignored.
- byte_valid outside HIGH, LOW and CHECK is ignored, with no side effects.
- Mid-load reset (rst=1):
  - The partial load is abandoned and the FSM returns to IDLE.
  - Memory words already written are not restored.

## Timing
- Reset values: state IDLE; byte_ready, wr_en, core_hold, done and error all 0; wr_addr 0; wr_data 0.
- All outputs are registered or decoded from state; no combinational path from byte_valid to byte_ready.
- core_hold is 1 in HIGH, LOW, WRITE and CHECK, and 0 in IDLE and DONE.
- core_hold rises the cycle after start is accepted.
- Throughput: at best 3 cycles per word (HIGH, LOW, WRITE); byte stalls extend HIGH or LOW indefinitely.
- wr_en, wr_addr and wr_data are stable together during the WRITE cycle.
- done rises the cycle after the last WRITE (no macro) or after CHECK (macro defined).

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - A running XOR of all data bytes accepted in the load is kept.
  - After the last WRITE, CHECK asserts byte_ready and accepts one checksum byte.
  - If that byte differs from the running XOR, error=1.
  - Then go to DONE.
  - A zero-word load skips CHECK.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state and no XOR register; error is tied to 0.

## Structure
- Package imem_loader_pkg:
  - state enum type.
  - ARQ and MEMORY_ADDR_SIZE default constants.
  - IMEM_DEPTH = 64.
  - BYTE_W = 8.
- No sub-module. A single FSM plus address counter, byte registers and the optional XOR register fit naturally in one module.

## Test plan
- Reset mid-load: rst after 3 of 5 words -> all outputs at reset values next cycle, wr_addr=0.
- Basic load: num_words=2, bytes 12,34,AB,CD with byte_valid held high -> writes 0x1234@0 and 0xABCD@1, 3 cycles apart; done 1 cycle after the second write.
- Backpressure: 10-cycle gap between the high and low byte -> byte_ready stays 1, no wr_en until the low byte arrives, word correct.
- Full depth and clamp: num_words=100 with 128 bytes -> 64 writes, last at address 63, no wrap; done=1, core_hold=0.
- Zero and ignored start: num_words=0 -> DONE the next cycle with no write. A start pulse during a load -> no effect on address or count.
- Checksum (macro defined): bytes 12,34 with checksum 26 -> error=0; with checksum 00 -> error=1; done=1 in both cases.
